id_ex_stage: RTL and testbench

Decode-to-execute pipeline register for the MIPS32 core. It sits directly downstream of the ID register file, capturing its two read ports together with decoded control. It resolves operand bypassing from the EX and MEM stages at capture time, detects load-use hazards, and inserts one bubble while stalling ID/IF. It also honours branch flush and downstream hold, and keeps a saturating stall-cycle counter.

---
 rtl/id_ex_stage.sv | 161 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand bypass select, load-use bubble,
// branch flush, downstream hold and a saturating stall counter.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [DATA_W-1:0] Read_Data_1_ID,
  input  logic [DATA_W-1:0] Read_Data_2_ID,
  input  logic [ADDR_W-1:0] Read_Address_1_ID,
  input  logic [ADDR_W-1:0] Read_Address_2_ID,
  input  logic              Uses_Rs_ID,
  input  logic              Uses_Rt_ID,
  input  logic [ADDR_W-1:0] Write_Register_ID,
  input  logic [15:0]       Imm_ID,
  input  logic              Instr_Valid_ID,
  input  logic              RegWrite_ID,
  input  logic              MemRead_ID,
  input  logic              MemWrite_ID,
  input  logic              ALUSrc_ID,
  input  logic [3:0]        ALUOp_ID,
  input  logic [DATA_W-1:0] ALU_Result_EX,
  input  logic [ADDR_W-1:0] Write_Register_MEM,
  input  logic              RegWrite_MEM,
  input  logic [DATA_W-1:0] Write_Data_MEM,
  input  logic              Flush_EX,
  input  logic              Hold_EX,
  output logic              Valid_EX,
  output logic [DATA_W-1:0] Operand_A_EX,
  output logic [DATA_W-1:0] Operand_B_EX,
  output logic [DATA_W-1:0] Store_Data_EX,
  output logic [ADDR_W-1:0] Write_Register_EX,
  output logic              RegWrite_EX,
  output logic              MemRead_EX,
  output logic              MemWrite_EX,
  output logic [3:0]        ALUOp_EX,
  output logic              Stall_ID,
  output logic [CNT_W-1:0]  Stall_Count
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [DATA_W-1:0] sd_q, sd_d;
  logic [ADDR_W-1:0] wr_q, wr_d;
  logic              rw_q, rw_d;
  logic              mr_q, mr_d;
  logic              mw_q, mw_d;
  logic [3:0]        aluop_q, aluop_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              ex_fwd_ok;
  logic [DATA_W-1:0] fwd_a, fwd_b, imm_ext;
  logic              load_use;

  // A load in EX has no data yet; it is caught as load-use instead.
  assign ex_fwd_ok = rw_q && valid_q && !mr_q;

  always_comb begin
    fwd_a = Read_Data_1_ID;
    if (Read_Address_1_ID == '0)
      fwd_a = '0;
    else if (ex_fwd_ok && wr_q == Read_Address_1_ID)
      fwd_a = ALU_Result_EX;
    else if (RegWrite_MEM && Write_Register_MEM == Read_Address_1_ID)
      fwd_a = Write_Data_MEM;
  end

  always_comb begin
    fwd_b = Read_Data_2_ID;
    if (Read_Address_2_ID == '0)
      fwd_b = '0;
    else if (ex_fwd_ok && wr_q == Read_Address_2_ID)
      fwd_b = ALU_Result_EX;
    else if (RegWrite_MEM && Write_Register_MEM == Read_Address_2_ID)
      fwd_b = Write_Data_MEM;
  end

  assign imm_ext = {{(DATA_W-16){Imm_ID[15]}}, Imm_ID};

  assign load_use = valid_q && mr_q && (wr_q != '0) && Instr_Valid_ID &&
                    ((Uses_Rs_ID && Read_Address_1_ID == wr_q) ||
                     (Uses_Rt_ID && Read_Address_2_ID == wr_q));

  assign Stall_ID = Hold_EX || load_use;

  always_comb begin
    valid_d = valid_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sd_d    = sd_q;
    wr_d    = wr_q;
    rw_d    = rw_q;
    mr_d    = mr_q;
    mw_d    = mw_q;
    aluop_d = aluop_q;
    if (Flush_EX || (!Hold_EX && load_use)) begin
      valid_d = 1'b0;
      rw_d    = 1'b0;
      mr_d    = 1'b0;
      mw_d    = 1'b0;
      aluop_d = '0;
    end else if (!Hold_EX) begin
      valid_d = Instr_Valid_ID;
      opa_d   = fwd_a;
      opb_d   = ALUSrc_ID ? imm_ext : fwd_b;
      sd_d    = fwd_b;
      wr_d    = Write_Register_ID;
      rw_d    = RegWrite_ID && Instr_Valid_ID;
      mr_d    = MemRead_ID && Instr_Valid_ID;
      mw_d    = MemWrite_ID && Instr_Valid_ID;
      aluop_d = Instr_Valid_ID ? ALUOp_ID : 4'd0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (Stall_ID && cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      valid_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      sd_q    <= '0;
      wr_q    <= '0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      aluop_q <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sd_q    <= sd_d;
      wr_q    <= wr_d;
      rw_q    <= rw_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      aluop_q <= aluop_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Valid_EX          = valid_q;
  assign Operand_A_EX      = opa_q;
  assign Operand_B_EX      = opb_q;
  assign Store_Data_EX     = sd_q;
  assign Write_Register_EX = wr_q;
  assign RegWrite_EX       = rw_q;
  assign MemRead_EX        = mr_q;
  assign MemWrite_EX       = mw_q;
  assign ALUOp_EX          = aluop_q;
  assign Stall_Count       = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic
// against a behavioural model of the EX register.
module tb_id_ex_stage;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [31:0] Read_Data_1_ID, Read_Data_2_ID;
  logic [4:0]  Read_Address_1_ID, Read_Address_2_ID;
  logic        Uses_Rs_ID, Uses_Rt_ID;
  logic [4:0]  Write_Register_ID;
  logic [15:0] Imm_ID;
  logic        Instr_Valid_ID;
  logic        RegWrite_ID, MemRead_ID, MemWrite_ID, ALUSrc_ID;
  logic [3:0]  ALUOp_ID;
  logic [31:0] ALU_Result_EX;
  logic [4:0]  Write_Register_MEM;
  logic        RegWrite_MEM;
  logic [31:0] Write_Data_MEM;
  logic        Flush_EX, Hold_EX;
  logic        Valid_EX;
  logic [31:0] Operand_A_EX, Operand_B_EX, Store_Data_EX;
  logic [4:0]  Write_Register_EX;
  logic        RegWrite_EX, MemRead_EX, MemWrite_EX;
  logic [3:0]  ALUOp_EX;
  logic        Stall_ID;
  logic [15:0] Stall_Count;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .Read_Data_1_ID(Read_Data_1_ID), .Read_Data_2_ID(Read_Data_2_ID),
    .Read_Address_1_ID(Read_Address_1_ID), .Read_Address_2_ID(Read_Address_2_ID),
    .Uses_Rs_ID(Uses_Rs_ID), .Uses_Rt_ID(Uses_Rt_ID),
    .Write_Register_ID(Write_Register_ID), .Imm_ID(Imm_ID),
    .Instr_Valid_ID(Instr_Valid_ID), .RegWrite_ID(RegWrite_ID),
    .MemRead_ID(MemRead_ID), .MemWrite_ID(MemWrite_ID),
    .ALUSrc_ID(ALUSrc_ID), .ALUOp_ID(ALUOp_ID),
    .ALU_Result_EX(ALU_Result_EX), .Write_Register_MEM(Write_Register_MEM),
    .RegWrite_MEM(RegWrite_MEM), .Write_Data_MEM(Write_Data_MEM),
    .Flush_EX(Flush_EX), .Hold_EX(Hold_EX),
    .Valid_EX(Valid_EX), .Operand_A_EX(Operand_A_EX),
    .Operand_B_EX(Operand_B_EX), .Store_Data_EX(Store_Data_EX),
    .Write_Register_EX(Write_Register_EX), .RegWrite_EX(RegWrite_EX),
    .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX),
    .ALUOp_EX(ALUOp_EX), .Stall_ID(Stall_ID), .Stall_Count(Stall_Count)
  );

  always #5 Clk = ~Clk;

  task automatic clear_inputs();
    Read_Data_1_ID = '0; Read_Data_2_ID = '0;
    Read_Address_1_ID = '0; Read_Address_2_ID = '0;
    Uses_Rs_ID = 1'b0; Uses_Rt_ID = 1'b0;
    Write_Register_ID = '0; Imm_ID = '0; Instr_Valid_ID = 1'b0;
    RegWrite_ID = 1'b0; MemRead_ID = 1'b0; MemWrite_ID = 1'b0;
    ALUSrc_ID = 1'b0; ALUOp_ID = '0; ALU_Result_EX = '0;
    Write_Register_MEM = '0; RegWrite_MEM = 1'b0; Write_Data_MEM = '0;
    Flush_EX = 1'b0; Hold_EX = 1'b0;
  endtask

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    Rst_n = 1'b0;
    @(posedge Clk); #1;
    Rst_n = 1'b1;
  endtask

  task automatic drive_lw_r4();
    clear_inputs();
    Instr_Valid_ID = 1; RegWrite_ID = 1; MemRead_ID = 1; ALUSrc_ID = 1;
    Write_Register_ID = 5'd4; Read_Address_1_ID = 5'd2; Uses_Rs_ID = 1;
    Imm_ID = 16'd8; ALUOp_ID = 4'd2;
  endtask

  task automatic drive_r4_user();
    clear_inputs();
    Instr_Valid_ID = 1; RegWrite_ID = 1; Write_Register_ID = 5'd6;
    Read_Address_1_ID = 5'd1; Read_Address_2_ID = 5'd4;
    Uses_Rs_ID = 1; Uses_Rt_ID = 1; Read_Data_2_ID = 32'hDEAD;
  endtask

  task automatic test_reset();
    clear_inputs();
    Rst_n = 1'b0;
    #1;
    checks++; if (Valid_EX !== 1'b0) begin errors++; $display("FAIL reset_valid got %h exp 0", Valid_EX); end
    checks++; if (Operand_A_EX !== 32'h0 || Operand_B_EX !== 32'h0 || Store_Data_EX !== 32'h0) begin errors++; $display("FAIL reset_data got %h %h %h exp 0", Operand_A_EX, Operand_B_EX, Store_Data_EX); end
    checks++; if ({Write_Register_EX, RegWrite_EX, MemRead_EX, MemWrite_EX, ALUOp_EX} !== 12'h0) begin errors++; $display("FAIL reset_ctrl got %h exp 0", {Write_Register_EX, RegWrite_EX, MemRead_EX, MemWrite_EX, ALUOp_EX}); end
    checks++; if (Stall_Count !== 16'h0 || Stall_ID !== 1'b0) begin errors++; $display("FAIL reset_stall got %h/%h exp 0/0", Stall_Count, Stall_ID); end
    @(posedge Clk); #1;
    Rst_n = 1'b1;
  endtask

  task automatic test_add();
    do_reset();
    Instr_Valid_ID = 1; RegWrite_ID = 1; ALUOp_ID = 4'd2; Write_Register_ID = 5'd3;
    Read_Address_1_ID = 5'd1; Read_Address_2_ID = 5'd2;
    Uses_Rs_ID = 1; Uses_Rt_ID = 1;
    Read_Data_1_ID = 32'h5; Read_Data_2_ID = 32'h7;
    tick();
    checks++; if (Valid_EX !== 1'b1) begin errors++; $display("FAIL add_valid got %h exp 1", Valid_EX); end
    checks++; if (Operand_A_EX !== 32'h5) begin errors++; $display("FAIL add_opa got %h exp 5", Operand_A_EX); end
    checks++; if (Operand_B_EX !== 32'h7) begin errors++; $display("FAIL add_opb got %h exp 7", Operand_B_EX); end
    checks++; if (RegWrite_EX !== 1'b1 || Write_Register_EX !== 5'd3 || ALUOp_EX !== 4'd2) begin errors++; $display("FAIL add_ctrl got %h %h %h exp 1 3 2", RegWrite_EX, Write_Register_EX, ALUOp_EX); end
  endtask

  task automatic test_forward();
    do_reset();
    Instr_Valid_ID = 1; RegWrite_ID = 1; Write_Register_ID = 5'd1; ALUOp_ID = 4'd2;
    tick();
    clear_inputs();
    ALU_Result_EX = 32'hAA;
    RegWrite_MEM = 1; Write_Register_MEM = 5'd1; Write_Data_MEM = 32'hBB;
    Instr_Valid_ID = 1; RegWrite_ID = 1; Write_Register_ID = 5'd5;
    Read_Address_1_ID = 5'd1; Read_Address_2_ID = 5'd0;
    Uses_Rs_ID = 1; Uses_Rt_ID = 1;
    Read_Data_1_ID = 32'h11; Read_Data_2_ID = 32'h99;
    tick();
    checks++; if (Operand_A_EX !== 32'hAA) begin errors++; $display("FAIL fwd_ex_prio got %h exp aa", Operand_A_EX); end
    checks++; if (Store_Data_EX !== 32'h0) begin errors++; $display("FAIL fwd_r0 got %h exp 0", Store_Data_EX); end
    ALU_Result_EX = 32'hCC;
    tick();
    checks++; if (Operand_A_EX !== 32'hBB) begin errors++; $display("FAIL fwd_mem got %h exp bb", Operand_A_EX); end
  endtask

  task automatic test_load_use();
    do_reset();
    drive_lw_r4();
    tick();
    checks++; if (Valid_EX !== 1'b1 || MemRead_EX !== 1'b1) begin errors++; $display("FAIL lw_capture got %h/%h exp 1/1", Valid_EX, MemRead_EX); end
    drive_r4_user();
    #1;
    checks++; if (Stall_ID !== 1'b1) begin errors++; $display("FAIL lu_stall got %h exp 1", Stall_ID); end
    tick();
    checks++; if (Valid_EX !== 1'b0 || RegWrite_EX !== 1'b0) begin errors++; $display("FAIL lu_bubble got %h/%h exp 0/0", Valid_EX, RegWrite_EX); end
    checks++; if (Stall_ID !== 1'b0 || Stall_Count !== 16'd1) begin errors++; $display("FAIL lu_after got %h/%h exp 0/1", Stall_ID, Stall_Count); end
    RegWrite_MEM = 1; Write_Register_MEM = 5'd4; Write_Data_MEM = 32'h1234;
    tick();
    checks++; if (Valid_EX !== 1'b1 || Store_Data_EX !== 32'h1234) begin errors++; $display("FAIL lu_mem_fwd got %h/%h exp 1/1234", Valid_EX, Store_Data_EX); end
    checks++; if (Stall_Count !== 16'd1) begin errors++; $display("FAIL lu_count got %h exp 1", Stall_Count); end
  endtask

  task automatic test_imm();
    do_reset();
    Instr_Valid_ID = 1; RegWrite_ID = 1; ALUSrc_ID = 1; Imm_ID = 16'hFFFC;
    Read_Address_1_ID = 5'd3; Read_Address_2_ID = 5'd2; Uses_Rs_ID = 1;
    Read_Data_1_ID = 32'h10; Read_Data_2_ID = 32'h42; Write_Register_ID = 5'd2;
    tick();
    checks++; if (Operand_B_EX !== 32'hFFFFFFFC) begin errors++; $display("FAIL imm_sext got %h exp fffffffc", Operand_B_EX); end
    checks++; if (Store_Data_EX !== 32'h42) begin errors++; $display("FAIL imm_store got %h exp 42", Store_Data_EX); end
  endtask

  task automatic test_hold_flush();
    do_reset();
    Instr_Valid_ID = 1; RegWrite_ID = 1; MemWrite_ID = 1; ALUOp_ID = 4'd5;
    Read_Address_1_ID = 5'd1; Read_Data_1_ID = 32'h11; Write_Register_ID = 5'd7;
    tick();
    Hold_EX = 1; Read_Data_1_ID = 32'h22; ALUOp_ID = 4'd9; MemWrite_ID = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (Valid_EX !== 1'b1 || Operand_A_EX !== 32'h11 || ALUOp_EX !== 4'd5 || MemWrite_EX !== 1'b1) begin errors++; $display("FAIL hold_frozen%0d got %h %h %h %h exp 1 11 5 1", i, Valid_EX, Operand_A_EX, ALUOp_EX, MemWrite_EX); end
    end
    checks++; if (Stall_Count !== 16'd3) begin errors++; $display("FAIL hold_count got %h exp 3", Stall_Count); end
    Flush_EX = 1;
    tick();
    checks++; if (Valid_EX !== 1'b0 || RegWrite_EX !== 1'b0 || MemWrite_EX !== 1'b0) begin errors++; $display("FAIL hold_flush got %h %h %h exp 0 0 0", Valid_EX, RegWrite_EX, MemWrite_EX); end
    checks++; if (Stall_Count !== 16'd4) begin errors++; $display("FAIL hold_flush_count got %h exp 4", Stall_Count); end
    clear_inputs();
  endtask

  task automatic test_flush_load_use();
    do_reset();
    drive_lw_r4();
    tick();
    drive_r4_user();
    Flush_EX = 1;
    #1;
    checks++; if (Stall_ID !== 1'b1) begin errors++; $display("FAIL flu_stall got %h exp 1", Stall_ID); end
    tick();
    checks++; if (Valid_EX !== 1'b0 || RegWrite_EX !== 1'b0 || Stall_Count !== 16'd1) begin errors++; $display("FAIL flu_post got %h %h %h exp 0 0 1", Valid_EX, RegWrite_EX, Stall_Count); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive_lw_r4();
    tick();
    drive_r4_user();
    #1;
    checks++; if (Stall_ID !== 1'b1) begin errors++; $display("FAIL rms_pre got %h exp 1", Stall_ID); end
    Rst_n = 1'b0;
    #1;
    checks++; if (Stall_ID !== 1'b0 || Valid_EX !== 1'b0) begin errors++; $display("FAIL rms_async got %h/%h exp 0/0", Stall_ID, Valid_EX); end
    Rst_n = 1'b1;
    tick();
    checks++; if (Valid_EX !== 1'b1 || Store_Data_EX !== 32'hDEAD || Stall_Count !== 16'd0) begin errors++; $display("FAIL rms_capture got %h %h %h exp 1 dead 0", Valid_EX, Store_Data_EX, Stall_Count); end
  endtask

  task automatic test_saturate();
    do_reset();
    Hold_EX = 1;
    repeat (70000) @(posedge Clk);
    #1;
    checks++; if (Stall_Count !== 16'hFFFF) begin errors++; $display("FAIL sat_count got %h exp ffff", Stall_Count); end
    #3;
    Rst_n = 1'b0;
    #1;
    checks++; if (Stall_Count !== 16'h0 || Valid_EX !== 1'b0 || Operand_A_EX !== 32'h0 || RegWrite_EX !== 1'b0) begin errors++; $display("FAIL sat_reset got %h %h %h %h exp 0", Stall_Count, Valid_EX, Operand_A_EX, RegWrite_EX); end
    checks++; if (Stall_ID !== 1'b1) begin errors++; $display("FAIL sat_reset_hold got %h exp 1", Stall_ID); end
    Hold_EX = 0;
    Instr_Valid_ID = 1; Read_Address_1_ID = 5'd9; Read_Data_1_ID = 32'h77;
    #1;
    Rst_n = 1'b1;
    tick();
    checks++; if (Valid_EX !== 1'b1 || Operand_A_EX !== 32'h77) begin errors++; $display("FAIL sat_release got %h/%h exp 1/77", Valid_EX, Operand_A_EX); end
    clear_inputs();
  endtask

  // Behavioural model of what the EX register should hold.
  logic        m_valid, m_rw, m_mr, m_mw;
  logic [3:0]  m_op;
  logic [4:0]  m_wr;
  logic [31:0] m_a, m_b, m_sd;
  logic [15:0] m_cnt;

  function automatic logic [31:0] ref_fwd(input logic [4:0] addr, input logic [31:0] rf);
    if (addr == 0) return 32'h0;
    if (m_valid && m_rw && !m_mr && m_wr == addr) return ALU_Result_EX;
    if (RegWrite_MEM && Write_Register_MEM == addr) return Write_Data_MEM;
    return rf;
  endfunction

  task automatic test_random();
    logic lu, st;
    logic [31:0] fa, fb;
    do_reset();
    m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_op = 0; m_wr = 0;
    m_a = 0; m_b = 0; m_sd = 0; m_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      Read_Data_1_ID = $urandom; Read_Data_2_ID = $urandom;
      Read_Address_1_ID = 5'($urandom_range(0, 4));
      Read_Address_2_ID = 5'($urandom_range(0, 4));
      Uses_Rs_ID = 1'($urandom); Uses_Rt_ID = 1'($urandom);
      Write_Register_ID = 5'($urandom_range(0, 4));
      Imm_ID = 16'($urandom);
      Instr_Valid_ID = ($urandom_range(0, 7) != 0);
      RegWrite_ID = 1'($urandom); MemRead_ID = ($urandom_range(0, 2) == 0);
      MemWrite_ID = 1'($urandom); ALUSrc_ID = 1'($urandom);
      ALUOp_ID = 4'($urandom);
      ALU_Result_EX = $urandom;
      Write_Register_MEM = 5'($urandom_range(0, 4));
      RegWrite_MEM = 1'($urandom); Write_Data_MEM = $urandom;
      Flush_EX = ($urandom_range(0, 9) == 0);
      Hold_EX = ($urandom_range(0, 5) == 0);
      #1;
      lu = m_valid && m_mr && m_wr != 0 && Instr_Valid_ID &&
           ((Uses_Rs_ID && Read_Address_1_ID == m_wr) ||
            (Uses_Rt_ID && Read_Address_2_ID == m_wr));
      st = Hold_EX || lu;
      checks++; if (Stall_ID !== st) begin errors++; $display("FAIL rnd_stall_id[%0d] got %h exp %h", i, Stall_ID, st); end
      fa = ref_fwd(Read_Address_1_ID, Read_Data_1_ID);
      fb = ref_fwd(Read_Address_2_ID, Read_Data_2_ID);
      if (Flush_EX || (!Hold_EX && lu)) begin
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_op = 0;
      end else if (!Hold_EX) begin
        m_valid = Instr_Valid_ID;
        m_rw = RegWrite_ID & Instr_Valid_ID;
        m_mr = MemRead_ID & Instr_Valid_ID;
        m_mw = MemWrite_ID & Instr_Valid_ID;
        m_op = Instr_Valid_ID ? ALUOp_ID : 4'd0;
        m_wr = Write_Register_ID;
        m_a = fa;
        m_b = ALUSrc_ID ? 32'($signed(Imm_ID)) : fb;
        m_sd = fb;
      end
      if (st && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      tick();
      checks++; if ({Valid_EX, RegWrite_EX, MemRead_EX, MemWrite_EX, ALUOp_EX} !== {m_valid, m_rw, m_mr, m_mw, m_op}) begin errors++; $display("FAIL rnd_ctrl[%0d] got %h exp %h", i, {Valid_EX, RegWrite_EX, MemRead_EX, MemWrite_EX, ALUOp_EX}, {m_valid, m_rw, m_mr, m_mw, m_op}); end
      checks++; if (Stall_Count !== m_cnt) begin errors++; $display("FAIL rnd_count[%0d] got %h exp %h", i, Stall_Count, m_cnt); end
      if (m_valid) begin
        checks++; if (Operand_A_EX !== m_a || Operand_B_EX !== m_b || Store_Data_EX !== m_sd || Write_Register_EX !== m_wr) begin errors++; $display("FAIL rnd_data[%0d] got %h %h %h %h exp %h %h %h %h", i, Operand_A_EX, Operand_B_EX, Store_Data_EX, Write_Register_EX, m_a, m_b, m_sd, m_wr); end
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_add();
    test_forward();
    test_load_use();
    test_imm();
    test_hold_flush();
    test_flush_load_use();
    test_reset_mid_stall();
    test_random();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
